// File: rtl/clkdiv_pkg.sv
// Shared types and clamp constants for the clock divider bank.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        ALIGN,
        SETTLE,
        LOCKED
    } state_e;

    // A divide of 1 cannot produce a high and a low phase, so it runs as the minimum ratio.
    localparam int CLAMP_DIV_ODD = 1;
    localparam int CLAMP_DIV_MIN = 2;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: ratio/phase clamping, free-running counter and registered clock outputs.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] phase,
    output logic             outclk,
    output logic             outclk_en
);

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] phase_eff;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic             run;

    // Outputs are registered from the next count so they line up with the counter value.
    always_comb begin
        div_eff   = (div == DIV_W'(CLAMP_DIV_ODD)) ? DIV_W'(CLAMP_DIV_MIN) : div;
        phase_eff = (phase >= div_eff) ? div_eff - DIV_W'(1) : phase;
        half      = div_eff >> 1;
        run       = 1'b0;
        cnt_next  = '0;
        if (!hold && div != '0) begin
            run = 1'b1;
            if (load) begin
                cnt_next = phase_eff;
            end else if (cnt >= div_eff - DIV_W'(1)) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            outclk    <= 1'b0;
            outclk_en <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            outclk    <= run && (cnt_next < half);
            outclk_en <= run && (cnt_next == '0);
        end
    end

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of NUM_CLK divided clocks with shadow configuration and an align/settle/lock sequencer.
// Optional build macro CLKDIV_PHASE_EN enables per-channel start phase.
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int  NUM_CLK     = 2,
    parameter int  DIV_W       = 8,
    parameter int  DIV_DEFAULT = 2,
    parameter int  LOCK_CYCLES = 16,
    localparam int CHAN_W      = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CHAN_W-1:0]  cfg_chan,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [DIV_W-1:0]   cfg_phase,
    output logic [NUM_CLK-1:0] outclk,
    output logic [NUM_CLK-1:0] outclk_en,
    output logic               locked
);

    localparam int SETTLE_W = $clog2(LOCK_CYCLES + 1);

    state_e              state;
    state_e              next_state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                chan_ok;
    logic                write_hit;
    logic [DIV_W-1:0]    div_q [NUM_CLK];
    logic [DIV_W-1:0]    chan_phase [NUM_CLK];

    // Out-of-range channel writes are still accepted but change nothing.
    always_comb begin
        next_state = state;
        cfg_ready  = (state != ALIGN);
        chan_ok    = int'(cfg_chan) < NUM_CLK;
        write_hit  = cfg_valid && cfg_ready && chan_ok;
        case (state)
            ALIGN:   next_state = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_W'(LOCK_CYCLES - 1)) next_state = LOCKED;
            LOCKED:  next_state = LOCKED;
            default: next_state = ALIGN;
        endcase
        if (write_hit) begin
            next_state = ALIGN;
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state      <= ALIGN;
            settle_cnt <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= next_state;
            settle_cnt <= (state == SETTLE && next_state == SETTLE) ? settle_cnt + SETTLE_W'(1) : '0;
            locked     <= (next_state == LOCKED);
        end
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLK; i++) div_q[i] <= DIV_W'(DIV_DEFAULT);
        end else begin
            for (int i = 0; i < NUM_CLK; i++) begin
                if (write_hit && cfg_chan == CHAN_W'(i)) div_q[i] <= cfg_div;
            end
        end
    end

`ifdef CLKDIV_PHASE_EN
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLK; i++) chan_phase[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CLK; i++) begin
                if (write_hit && cfg_chan == CHAN_W'(i)) chan_phase[i] <= cfg_phase;
            end
        end
    end
`else
    logic unused_phase;
    assign unused_phase = ^cfg_phase;

    always_comb begin
        for (int i = 0; i < NUM_CLK; i++) chan_phase[i] = '0;
    end
`endif

    // Channels are silenced whenever the sequencer is heading into ALIGN and reloaded as it leaves.
    for (genvar g = 0; g < NUM_CLK; g++) begin : g_chan
        clkdiv_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .refclk    (refclk),
            .rst       (rst),
            .hold      (next_state == ALIGN),
            .load      (state == ALIGN),
            .div       (div_q[g]),
            .phase     (chan_phase[g]),
            .outclk    (outclk[g]),
            .outclk_en (outclk_en[g])
        );
    end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed self-checking bench for clkdiv_bank (three channels, default lock settings).
module tb_clkdiv_bank;

    logic       refclk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_chan;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic [2:0] outclk;
    logic [2:0] outclk_en;
    logic       locked;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [1:0] chan;
        logic [7:0] div;
        int         period;
        int         high;
        bit         on;
    } vec_t;

    vec_t vecs [6];

    clkdiv_bank #(
        .NUM_CLK     (3),
        .DIV_W       (8),
        .DIV_DEFAULT (2),
        .LOCK_CYCLES (16)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .outclk    (outclk),
        .outclk_en (outclk_en),
        .locked    (locked)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issues one write at the next edge and returns 1ns after that edge.
    task automatic applyStimulus(input logic [1:0] chan, input logic [7:0] div, input logic [7:0] phase);
        @(negedge refclk);
        cfg_valid = 1'b1;
        cfg_chan  = chan;
        cfg_div   = div;
        cfg_phase = phase;
        @(posedge refclk);
        #1;
        cfg_valid = 1'b0;
    endtask

    // k=0 is the current sample point (just after a write edge or just before the first edge after reset).
    task automatic runWindow(input int c, input int p, input int h, input bit on, input int kmax);
        for (int k = 0; k <= kmax; k++) begin
            if (k > 0) begin
                @(posedge refclk);
                #1;
            end
            checkOutput($sformatf("locked k%0d", k), 8'(locked), 8'(k >= 17));
            checkOutput($sformatf("cfg_ready k%0d", k), 8'(cfg_ready), 8'(k >= 1));
            if (k == 0) begin
                checkOutput("outclk silent", 8'(outclk), 8'h0);
                checkOutput("outclk_en silent", 8'(outclk_en), 8'h0);
            end else if (k - 1 < 2 * p) begin
                checkOutput($sformatf("outclk[%0d] k%0d", c, k), 8'(outclk[c]), 8'(on && ((k - 1) % p < h)));
                checkOutput($sformatf("outclk_en[%0d] k%0d", c, k), 8'(outclk_en[c]), 8'(on && ((k - 1) % p == 0)));
            end
        end
    endtask

    initial begin
        int n0;
        int n1;
        bit e0;

        vecs[0] = '{chan: 2'd1, div: 8'd5, period: 5, high: 2, on: 1'b1};
        vecs[1] = '{chan: 2'd0, div: 8'd4, period: 4, high: 2, on: 1'b1};
        vecs[2] = '{chan: 2'd2, div: 8'd0, period: 1, high: 0, on: 1'b0};
        vecs[3] = '{chan: 2'd2, div: 8'd1, period: 2, high: 1, on: 1'b1};
        vecs[4] = '{chan: 2'd0, div: 8'd3, period: 3, high: 1, on: 1'b1};
        vecs[5] = '{chan: 2'd1, div: 8'd7, period: 7, high: 3, on: 1'b1};

        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
        cfg_phase = '0;
        #1;
        checkOutput("reset outclk", 8'(outclk), 8'h0);
        checkOutput("reset outclk_en", 8'(outclk_en), 8'h0);
        checkOutput("reset locked", 8'(locked), 8'h0);
        checkOutput("reset cfg_ready", 8'(cfg_ready), 8'h0);

        repeat (2) @(negedge refclk);
        rst = 1'b1;
        runWindow(0, 2, 1, 1'b1, 17);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].chan, vecs[i].div, 8'd0);
            runWindow(vecs[i].chan, vecs[i].period, vecs[i].high, vecs[i].on,
                      (2 * vecs[i].period > 17) ? 2 * vecs[i].period : 17);
        end

        // Out-of-range channel: stays locked and existing ratios keep running.
        applyStimulus(2'd3, 8'd9, 8'd0);
        checkOutput("oor locked", 8'(locked), 8'h1);
        checkOutput("oor cfg_ready", 8'(cfg_ready), 8'h1);
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 21; k++) begin
            @(posedge refclk);
            #1;
            n0 += int'(outclk_en[0]);
            n1 += int'(outclk_en[1]);
        end
        checkOutput("oor en0 pulses", 8'(n0), 8'd7);
        checkOutput("oor en1 pulses", 8'(n1), 8'd3);
        checkOutput("oor still locked", 8'(locked), 8'h1);

        // Second write lands 5 edges into SETTLE and restarts the lock count.
        applyStimulus(2'd0, 8'd4, 8'd1);
        repeat (5) @(posedge refclk);
        #1;
        checkOutput("settle locked", 8'(locked), 8'h0);
        checkOutput("settle cfg_ready", 8'(cfg_ready), 8'h1);
        applyStimulus(2'd1, 8'd4, 8'd0);
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) begin
                @(posedge refclk);
                #1;
            end
            checkOutput($sformatf("relock k%0d", k), 8'(locked), 8'(k >= 17));
            if (k >= 1 && k <= 12) begin
`ifdef CLKDIV_PHASE_EN
                e0 = ((k % 4) == 0);
`else
                e0 = (((k - 1) % 4) == 0);
`endif
                checkOutput($sformatf("phase en0 k%0d", k), 8'(outclk_en[0]), 8'(e0));
                checkOutput($sformatf("phase en1 k%0d", k), 8'(outclk_en[1]), 8'(((k - 1) % 4) == 0));
            end
        end

        // Asynchronous reset while locked, then defaults return.
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async outclk", 8'(outclk), 8'h0);
        checkOutput("async outclk_en", 8'(outclk_en), 8'h0);
        checkOutput("async locked", 8'(locked), 8'h0);
        checkOutput("async cfg_ready", 8'(cfg_ready), 8'h0);
        @(negedge refclk);
        rst = 1'b1;
        runWindow(1, 2, 1, 1'b1, 17);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 SHALL have parameter NUM_CLK, default 2, number of output clock channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8, width of divide and phase fields.
REQ-003 SHALL have parameter DIV_DEFAULT, default 2, divide ratio loaded into every channel at reset.
REQ-004 SHALL have parameter LOCK_CYCLES, default 16, settle count before locked asserts (>=1).
REQ-005 SHALL have port refclk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port cfg_valid  input  1  configuration write request.
REQ-008 SHALL have port cfg_ready  output  1  configuration write can be accepted.
REQ-009 SHALL have port cfg_chan  input  clog2(NUM_CLK) (min 1)  target channel.
REQ-010 SHALL have port cfg_div  input  DIV_W  divide ratio; 0 = channel disabled.
REQ-011 SHALL have port cfg_phase  input  DIV_W  start offset in refclk cycles.
REQ-012 SHALL have port outclk  output  NUM_CLK  registered divided clocks.
REQ-013 SHALL have port outclk_en  output  NUM_CLK  one-cycle pulse per output period.
REQ-014 SHALL have port locked  output  1  all channels aligned and settled.

Function
REQ-015 SHALL accept a write on a refclk edge where cfg_valid and cfg_ready are both high, updating the shadow div/phase of cfg_chan only.
REQ-016 SHALL implement states ALIGN, SETTLE, LOCKED; an accepted write in any state moves to ALIGN on the same edge.
REQ-017 SHALL drive cfg_ready low in ALIGN, high in SETTLE and LOCKED.
REQ-018 SHALL, in ALIGN, hold all outclk/outclk_en low and move to SETTLE on the next edge, loading every channel counter with its phase.
REQ-019 SHALL, in SETTLE, count LOCK_CYCLES edges and then enter LOCKED; locked is high only in LOCKED (registered).
REQ-020 SHALL run each enabled channel counter 0..div-1, wrapping to 0; outclk high while count < floor(div/2); outclk_en high when count == 0.
REQ-021 SHALL clamp div==1 to 2 and phase>=div to div-1; a div==0 channel holds outclk and outclk_en low.
REQ-022 SHALL keep channels free-running in SETTLE and LOCKED; write during SETTLE restarts ALIGN and the settle count.
REQ-023 SHALL ignore cfg_chan >= NUM_CLK writes (accepted, no register change, no state change).

Reset
REQ-024 SHALL on rst low set state ALIGN, all shadow div = DIV_DEFAULT, phase = 0, counters 0, settle count 0, outclk 0, outclk_en 0, locked 0, cfg_ready 0.
REQ-025 SHALL, with no writes, assert locked after edge 1+LOCK_CYCLES following rst release; rst assertion mid-operation drops every output within the same cycle.

Configuration
REQ-026 SHALL, with macro CLKDIV_PHASE_EN defined, honour cfg_phase per REQ-018/021.
REQ-027 SHALL, without CLKDIV_PHASE_EN, omit phase storage, ignore cfg_phase and load all counters with 0 in ALIGN.

Structure
REQ-028 SHALL place the state enum (ALIGN/SETTLE/LOCKED) and the clamp constants in package clkdiv_pkg.
REQ-029 SHALL implement one channel (counter, clamp, outclk/outclk_en regs) as sub-module clkdiv_chan, instantiated NUM_CLK times.

Verification
REQ-030 SHALL cover reset release, defaults: outclk[0] toggles every cycle pair (div 2), locked rises after edge 17, cfg_ready high from edge 1.
REQ-031 SHALL cover write chan 1 div=5 phase=0 while LOCKED: locked falls next edge, outclk[1] high 2 / low 3 cycles, outclk_en[1] every 5 cycles, locked back after 17 edges.
REQ-032 SHALL cover chan 0 div=4 phase=1 vs chan 1 div=4 phase=0 (CLKDIV_PHASE_EN): outclk_en[0] pulses exactly 1 cycle before outclk_en[1].
REQ-033 SHALL cover div=0 and div=1 writes: disabled channel stays low; div=1 behaves as div=2.
REQ-034 SHALL cover a second write 5 edges into SETTLE: locked delayed to 17 edges after that write; rst pulse while LOCKED clears all outputs asynchronously.
